// File: rtl/baser_pkg.sv
// Shared 64B/66B and 256B/257B definitions used by the transcoder and the receive checker.
package baser_pkg;

  localparam int unsigned DATA_WIDTH    = 64;
  localparam int unsigned HDR_WIDTH     = 2;
  localparam int unsigned FRAME_WIDTH   = DATA_WIDTH + HDR_WIDTH;
  localparam int unsigned TC_DATA_WIDTH = 4 * DATA_WIDTH;
  localparam int unsigned TC_WIDTH      = TC_DATA_WIDTH + 1;
  localparam int unsigned LANES         = 4;
  localparam int unsigned CNT_WIDTH     = 32;

  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_CTRL = 2'b01;

  localparam logic [7:0] BT_C8 = 8'h1E;
  localparam logic [7:0] BT_S0 = 8'h78;
  localparam logic [7:0] BT_O0 = 8'h4B;
  localparam logic [7:0] BT_T0 = 8'h87;
  localparam logic [7:0] BT_T1 = 8'h99;
  localparam logic [7:0] BT_T2 = 8'hAA;
  localparam logic [7:0] BT_T3 = 8'hB4;
  localparam logic [7:0] BT_T4 = 8'hCC;
  localparam logic [7:0] BT_T5 = 8'hD2;
  localparam logic [7:0] BT_T6 = 8'hE1;
  localparam logic [7:0] BT_T7 = 8'hFF;

  // One 66b block: sync header in the low two bits, payload above it.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] payload;
    logic [HDR_WIDTH-1:0]  sh;
  } block66_t;

  // Block types whose low nibble uniquely identifies them, so the upper nibble can be dropped.
  function automatic logic is_valid_first_type(input logic [7:0] bt);
    case (bt)
      BT_C8, BT_S0, BT_O0, BT_T0, BT_T1, BT_T2,
      BT_T3, BT_T4, BT_T5, BT_T6, BT_T7: is_valid_first_type = 1'b1;
      default:                          is_valid_first_type = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/baser_257b_pack.sv
// Combinational 4x66b -> 257b transcoder with data/error classification.
module baser_257b_pack
  import baser_pkg::*;
(
  input  block66_t [LANES-1:0]  blocks,
  output logic [TC_WIDTH-1:0]   xcoded_c,
  output logic                  is_data_c,
  output logic                  is_err_c
);

  logic [TC_DATA_WIDTH-1:0] payloads_c;
  logic                     bad_sh_c;
  logic                     found_c;
  logic [1:0]               first_k_c;
  logic [7:0]               first_type_c;

  // Scan headers: all-data flag, illegal headers, position and type of the first ctrl block.
  always_comb begin
    payloads_c   = '0;
    is_data_c    = 1'b1;
    bad_sh_c     = 1'b0;
    found_c      = 1'b0;
    first_k_c    = 2'd0;
    first_type_c = 8'd0;
    for (int i = 0; i < int'(LANES); i++) begin
      payloads_c[i*DATA_WIDTH +: DATA_WIDTH] = blocks[i].payload;
      if (blocks[i].sh != SH_DATA) is_data_c = 1'b0;
      if (blocks[i].sh != SH_DATA && blocks[i].sh != SH_CTRL) bad_sh_c = 1'b1;
      if (blocks[i].sh == SH_CTRL && !found_c) begin
        found_c      = 1'b1;
        first_k_c    = 2'(i);
        first_type_c = blocks[i].payload[7:0];
      end
    end
    is_err_c = bad_sh_c | (found_c & ~is_valid_first_type(first_type_c));
  end

  // Assemble the 257b word; blocks before the first ctrl shift up by 4 to make room for the flags.
  always_comb begin
    xcoded_c = '0;
    if (is_err_c) begin
      xcoded_c = {payloads_c[TC_DATA_WIDTH-1:8], payloads_c[3:0], 4'b1111, 1'b0};
    end else if (is_data_c) begin
      xcoded_c = {payloads_c, 1'b1};
    end else begin
      for (int i = 0; i < int'(LANES); i++) begin
        xcoded_c[i+1] = (blocks[i].sh == SH_DATA);
        if (2'(i) < first_k_c) begin
          xcoded_c[i*DATA_WIDTH+5 +: DATA_WIDTH] = blocks[i].payload;
        end else if (2'(i) == first_k_c) begin
          xcoded_c[i*DATA_WIDTH+5 +: 4]  = blocks[i].payload[3:0];
          xcoded_c[i*DATA_WIDTH+9 +: 56] = blocks[i].payload[63:8];
        end else begin
          xcoded_c[i*DATA_WIDTH+1 +: DATA_WIDTH] = blocks[i].payload;
        end
      end
    end
  end

endmodule

// File: rtl/baser_257b_transcoder.sv
// Tx 64B/66B -> 256B/257B transcoder: gathers four 66b blocks and emits one registered 257b block.
module baser_257b_transcoder
  import baser_pkg::*;
(
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [FRAME_WIDTH-1:0] i_tx_coded,
  output logic                   o_valid,
  output logic [TC_WIDTH-1:0]    o_tx_xcoded,
  output logic [1:0]             o_lane,
  output logic [CNT_WIDTH-1:0]   o_block_count,
  output logic [CNT_WIDTH-1:0]   o_data_count,
  output logic [CNT_WIDTH-1:0]   o_ctrl_count,
  output logic [CNT_WIDTH-1:0]   o_err_count
);

  block66_t [LANES-2:0] slots;
  block66_t [LANES-1:0] group_c;
  logic [TC_WIDTH-1:0]  xcoded_c;
  logic                 is_data_c;
  logic                 is_err_c;
  logic                 emit_c;

  // The live input stands in as slot 3 so the word is ready on the accepting edge.
  assign group_c = {i_tx_coded, slots};
  assign emit_c  = i_valid && (o_lane == 2'd3);

  baser_257b_pack u_pack (
    .blocks    (group_c),
    .xcoded_c  (xcoded_c),
    .is_data_c (is_data_c),
    .is_err_c  (is_err_c)
  );

  // Lane counter, gather slots, output register and statistics counters.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_lane        <= 2'd0;
      slots         <= '0;
      o_valid       <= 1'b0;
      o_tx_xcoded   <= '0;
      o_block_count <= '0;
      o_data_count  <= '0;
      o_ctrl_count  <= '0;
      o_err_count   <= '0;
    end else begin
      o_valid <= 1'b0;
      if (i_valid) begin
        o_lane <= o_lane + 2'd1;
        if (o_lane != 2'd3) slots[o_lane] <= i_tx_coded;
      end
      if (emit_c) begin
        o_valid       <= 1'b1;
        o_tx_xcoded   <= xcoded_c;
        o_block_count <= o_block_count + 32'd1;
        if (is_err_c)       o_err_count  <= o_err_count + 32'd1;
        else if (is_data_c) o_data_count <= o_data_count + 32'd1;
        else                o_ctrl_count <= o_ctrl_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_baser_257b_transcoder.sv
// Directed self-checking bench for baser_257b_transcoder, including a 257b decode round-trip.
module tb_baser_257b_transcoder;

  logic         clk;
  logic         i_rst_n;
  logic         i_valid;
  logic [65:0]  i_tx_coded;
  logic         o_valid;
  logic [256:0] o_tx_xcoded;
  logic [1:0]   o_lane;
  logic [31:0]  o_block_count;
  logic [31:0]  o_data_count;
  logic [31:0]  o_ctrl_count;
  logic [31:0]  o_err_count;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] AA = 64'hAAAA_AAAA_AAAA_AAAA;

  baser_257b_transcoder dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .i_tx_coded    (i_tx_coded),
    .o_valid       (o_valid),
    .o_tx_xcoded   (o_tx_xcoded),
    .o_lane        (o_lane),
    .o_block_count (o_block_count),
    .o_data_count  (o_data_count),
    .o_ctrl_count  (o_ctrl_count),
    .o_err_count   (o_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receive-side reconstruction of the ctrl type from its surviving low nibble.
  function automatic logic [7:0] nib_to_type(input logic [3:0] n);
    case (n)
      4'hE: nib_to_type = 8'h1E;
      4'h8: nib_to_type = 8'h78;
      4'hB: nib_to_type = 8'h4B;
      4'h7: nib_to_type = 8'h87;
      4'h9: nib_to_type = 8'h99;
      4'hA: nib_to_type = 8'hAA;
      4'h4: nib_to_type = 8'hB4;
      4'hC: nib_to_type = 8'hCC;
      4'h2: nib_to_type = 8'hD2;
      4'h1: nib_to_type = 8'hE1;
      4'hF: nib_to_type = 8'hFF;
      default: nib_to_type = 8'h00;
    endcase
  endfunction

  // Decode a non-error 257b word back into {b3,b2,b1,b0}, each {payload, sh}.
  function automatic logic [263:0] decode(input logic [256:0] x);
    logic [263:0] r;
    logic [3:0]   fl;
    int           k;
    r  = '0;
    fl = x[4:1];
    if (x[0]) begin
      for (int i = 0; i < 4; i++) r[66*i +: 66] = {x[64*i+1 +: 64], 2'b10};
    end else begin
      k = 4;
      for (int i = 3; i >= 0; i--) if (!fl[i]) k = i;
      for (int i = 0; i < 4; i++) begin
        if (i < k)       r[66*i +: 66] = {x[64*i+5 +: 64], 2'b10};
        else if (i == k) r[66*i +: 66] = {x[64*i+9 +: 56], nib_to_type(x[64*i+5 +: 4]), 2'b01};
        else             r[66*i +: 66] = {x[64*i+1 +: 64], fl[i] ? 2'b10 : 2'b01};
      end
    end
    return r;
  endfunction

  // Drive four consecutive valid blocks; returns on the sampling edge where the emit is visible.
  task automatic send_group(input logic [65:0] b0, input logic [65:0] b1,
                            input logic [65:0] b2, input logic [65:0] b3);
    @(negedge clk); i_valid = 1'b1; i_tx_coded = b0;
    @(negedge clk); i_tx_coded = b1;
    @(negedge clk); i_tx_coded = b2;
    @(negedge clk); i_tx_coded = b3;
    @(negedge clk); i_valid = 1'b0; i_tx_coded = '0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_tx_coded = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({o_valid, o_lane, o_block_count, o_data_count, o_ctrl_count, o_err_count} !== '0 ||
        o_tx_xcoded !== '0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%0b lane=%0d blk=%0d xc=%h required all zero",
               o_valid, o_lane, o_block_count, o_tx_xcoded);
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_all_data();
    logic [256:0] exp;
    logic [256:0] held;
    exp = {{4{AA}}, 1'b1};
    send_group({AA, 2'b10}, {AA, 2'b10}, {AA, 2'b10}, {AA, 2'b10});
    n_cmp++;
    if (o_valid !== 1'b1 || o_tx_xcoded !== exp) begin
      n_bad++;
      $display("FAIL all_data_word: valid=%0b got=%h required=%h", o_valid, o_tx_xcoded, exp);
    end
    n_cmp++;
    if (o_block_count !== 32'd1 || o_data_count !== 32'd1) begin
      n_bad++;
      $display("FAIL all_data_counts: blk=%0d data=%0d required 1/1", o_block_count, o_data_count);
    end
    held = o_tx_xcoded;
    @(negedge clk);
    n_cmp++;
    if (o_valid !== 1'b0 || o_tx_xcoded !== exp) begin
      n_bad++;
      $display("FAIL emit_pulse_hold: valid=%0b got=%h required valid=0 word=%h (prev %h)",
               o_valid, o_tx_xcoded, exp, held);
    end
  endtask

  task automatic test_ctrl_first();
    logic [256:0] exp;
    exp = {{3{AA}}, 56'h0, 4'hE, 4'b1110, 1'b0};
    send_group({56'h0, 8'h1E, 2'b01}, {AA, 2'b10}, {AA, 2'b10}, {AA, 2'b10});
    n_cmp++;
    if (o_valid !== 1'b1 || o_tx_xcoded !== exp) begin
      n_bad++;
      $display("FAIL ctrl_k0_word: valid=%0b got=%h required=%h", o_valid, o_tx_xcoded, exp);
    end
    n_cmp++;
    if (o_ctrl_count !== 32'd1) begin
      n_bad++;
      $display("FAIL ctrl_k0_count: ctrl=%0d required 1", o_ctrl_count);
    end
  endtask

  task automatic test_ctrl_mixed();
    logic [256:0] exp;
    logic [63:0]  p0;
    exp = {56'h0, 8'h1E, 56'h0, 4'h7, AA, AA, 4'b0011, 1'b0};
    send_group({AA, 2'b10}, {AA, 2'b10}, {56'h0, 8'h87, 2'b01}, {56'h0, 8'h1E, 2'b01});
    n_cmp++;
    if (o_valid !== 1'b1 || o_tx_xcoded !== exp) begin
      n_bad++;
      $display("FAIL ctrl_k2_word: valid=%0b got=%h required=%h", o_valid, o_tx_xcoded, exp);
    end
    // A later ctrl block with a non-first-legal type is carried whole, not flagged as error.
    p0  = {56'h01_0203_0405_0607, 8'h1E};
    exp = {AA, AA, 56'h0, 8'h55, p0[63:8], 4'hE, 4'b1100, 1'b0};
    send_group({p0, 2'b01}, {56'h0, 8'h55, 2'b01}, {AA, 2'b10}, {AA, 2'b10});
    n_cmp++;
    if (o_tx_xcoded !== exp || o_ctrl_count !== 32'd3 || o_err_count !== 32'd0) begin
      n_bad++;
      $display("FAIL later_ctrl_kept: got=%h ctrl=%0d err=%0d required=%h ctrl=3 err=0",
               o_tx_xcoded, o_ctrl_count, o_err_count, exp);
    end
  endtask

  task automatic test_errors();
    logic [255:0] allp;
    logic [256:0] exp;
    logic [63:0]  p2;
    p2   = 64'h1234_5678_9ABC_DEF0;
    allp = {AA, p2, AA, AA};
    exp  = {allp[255:8], allp[3:0], 4'b1111, 1'b0};
    send_group({AA, 2'b10}, {AA, 2'b10}, {p2, 2'b11}, {AA, 2'b10});
    n_cmp++;
    if (o_tx_xcoded[4:0] !== 5'b11110 || o_tx_xcoded !== exp) begin
      n_bad++;
      $display("FAIL err_sh11_word: got=%h required=%h", o_tx_xcoded, exp);
    end
    n_cmp++;
    if (o_err_count !== 32'd1) begin
      n_bad++;
      $display("FAIL err_sh11_count: err=%0d required 1", o_err_count);
    end
    send_group({AA, 2'b10}, {56'hDE_ADBE_EFCA_FE00, 8'h55, 2'b01}, {AA, 2'b10}, {AA, 2'b10});
    n_cmp++;
    if (o_tx_xcoded[4:0] !== 5'b11110 || o_err_count !== 32'd2 || o_ctrl_count !== 32'd3) begin
      n_bad++;
      $display("FAIL err_bad_type: lo=%b err=%0d ctrl=%0d required 11110 err=2 ctrl=3",
               o_tx_xcoded[4:0], o_err_count, o_ctrl_count);
    end
    send_group({AA, 2'b00}, {AA, 2'b10}, {AA, 2'b10}, {AA, 2'b10});
    n_cmp++;
    if (o_tx_xcoded[4:0] !== 5'b11110 || o_err_count !== 32'd3 || o_block_count !== 32'd7) begin
      n_bad++;
      $display("FAIL err_sh00: lo=%b err=%0d blk=%0d required 11110 err=3 blk=7",
               o_tx_xcoded[4:0], o_err_count, o_block_count);
    end
  endtask

  task automatic test_valid_gaps();
    int exp_lane [8] = '{0, 1, 1, 1, 2, 3, 3, 0};
    int pat      [7] = '{1, 0, 0, 1, 1, 0, 1};
    int bad;
    bad = 0;
    n_cmp++;
    if (o_lane !== 2'(exp_lane[0])) begin
      n_bad++;
      $display("FAIL gap_lane_start: lane=%0d required %0d", o_lane, exp_lane[0]);
    end
    for (int c = 0; c < 7; c++) begin
      i_valid    = (pat[c] != 0);
      i_tx_coded = {AA, 2'b10};
      @(negedge clk);
      n_cmp++;
      if (o_lane !== 2'(exp_lane[c+1]) || o_valid !== (c == 6)) begin
        n_bad++;
        $display("FAIL gap_step%0d: lane=%0d valid=%0b required lane=%0d valid=%0b",
                 c, o_lane, o_valid, exp_lane[c+1], (c == 6));
      end
    end
    i_valid = 1'b0;
    n_cmp++;
    if (o_tx_xcoded !== {{4{AA}}, 1'b1} || o_block_count !== 32'd8 ||
        o_block_count !== o_data_count + o_ctrl_count + o_err_count) begin
      n_bad++;
      $display("FAIL gap_emit: xc=%h blk=%0d data=%0d ctrl=%0d err=%0d required blk=8 sum-consistent",
               o_tx_xcoded, o_block_count, o_data_count, o_ctrl_count, o_err_count);
    end
  endtask

  task automatic test_reset_mid_group();
    logic [63:0]  p [4];
    logic [256:0] exp;
    int           emits;
    p   = '{64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444,
            64'h5555_6666_7777_8888, 64'h9999_0000_FEDC_BA98};
    exp = {p[3], p[2], p[1], p[0], 1'b1};
    @(negedge clk); i_valid = 1'b1; i_tx_coded = {AA, 2'b00};
    @(negedge clk);
    @(negedge clk); i_valid = 1'b0;
    n_cmp++;
    if (o_lane !== 2'd2) begin
      n_bad++;
      $display("FAIL pre_reset_lane: lane=%0d required 2", o_lane);
    end
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_lane !== 2'd0 || o_block_count !== '0 || o_err_count !== '0 || o_tx_xcoded !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_clear: lane=%0d blk=%0d err=%0d required 0", o_lane, o_block_count, o_err_count);
    end
    @(negedge clk); i_rst_n = 1'b1;
    emits = 0;
    @(negedge clk); i_valid = 1'b1; i_tx_coded = {p[0], 2'b10}; emits += int'(o_valid);
    @(negedge clk); i_tx_coded = {p[1], 2'b10}; emits += int'(o_valid);
    @(negedge clk); i_tx_coded = {p[2], 2'b10}; emits += int'(o_valid);
    @(negedge clk); i_tx_coded = {p[3], 2'b10}; emits += int'(o_valid);
    @(negedge clk); i_valid = 1'b0; emits += int'(o_valid);
    n_cmp++;
    if (emits != 1 || o_tx_xcoded !== exp) begin
      n_bad++;
      $display("FAIL post_reset_group: emits=%0d got=%h required 1 emit of %h", emits, o_tx_xcoded, exp);
    end
    n_cmp++;
    if (o_block_count !== 32'd1 || o_data_count !== 32'd1 || o_ctrl_count !== 32'd0 || o_err_count !== 32'd0) begin
      n_bad++;
      $display("FAIL post_reset_counts: blk=%0d data=%0d ctrl=%0d err=%0d required 1/1/0/0",
               o_block_count, o_data_count, o_ctrl_count, o_err_count);
    end
  endtask

  task automatic test_roundtrip();
    logic [7:0]   vt [11] = '{8'h1E, 8'h78, 8'h4B, 8'h87, 8'h99, 8'hAA,
                              8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    logic [65:0]  b [4];
    logic [263:0] sent;
    logic [263:0] got;
    for (int t = 0; t < 11; t++) begin
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 4; i++) begin
          if (i < k)       b[i] = {$urandom, $urandom, 2'b10};
          else if (i == k) b[i] = {$urandom, 24'($urandom), vt[t], 2'b01};
          else if (((t + k) % 2) == 0) b[i] = {$urandom, 24'($urandom), 8'h2D, 2'b01};
          else             b[i] = {$urandom, $urandom, 2'b10};
        end
        sent = {b[3], b[2], b[1], b[0]};
        send_group(b[0], b[1], b[2], b[3]);
        got = decode(o_tx_xcoded);
        n_cmp++;
        if (o_valid !== 1'b1 || o_tx_xcoded[0] !== 1'b0 || got !== sent) begin
          n_bad++;
          $display("FAIL roundtrip_t%02h_k%0d: valid=%0b got=%h required=%h", vt[t], k, o_valid, got, sent);
        end
      end
    end
    n_cmp++;
    if (o_ctrl_count !== 32'd44 || o_block_count !== 32'd45 || o_data_count !== 32'd1 || o_err_count !== 32'd0) begin
      n_bad++;
      $display("FAIL roundtrip_counts: blk=%0d data=%0d ctrl=%0d err=%0d required 45/1/44/0",
               o_block_count, o_data_count, o_ctrl_count, o_err_count);
    end
  endtask

  initial begin
    test_reset();
    test_all_data();
    test_ctrl_first();
    test_ctrl_mixed();
    test_errors();
    test_valid_gaps();
    test_reset_mid_group();
    test_roundtrip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
